// File: rtl/shift_exec_pipe_pkg.sv
// Shared definitions for the shift execution pipe: R-type funct codes and
// the decoded operand bundle staged in S1.
package shift_exec_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    typedef struct packed {
        logic [DATA_W-1:0] rt;
        logic [AMT_W-1:0]  amt;
        logic              right;
        logic              arith;
        logic              illegal;
    } s1_data_t;

endpackage

// File: rtl/shift_exec_pipe_shift_mux.sv
// Combinational 32-bit barrel shifter: five log-steps, each conditionally
// shifting by 2^gi left or right, with sign fill for arithmetic right shifts.
module shift_mux
    import shift_exec_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [AMT_W-1:0]  sa,
    input  logic              right,
    input  logic              arith,
    output logic [DATA_W-1:0] y
);

    logic fill;
    assign fill = arith & d[DATA_W-1];

    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        logic [DATA_W-1:0] d_in;
        logic [DATA_W-1:0] d_out;

        if (gi == 0) begin : g_first
            assign d_in = d;
        end else begin : g_chain
            assign d_in = g_stage[gi-1].d_out;
        end

        assign d_out = !sa[gi] ? d_in :
                       right   ? {{SH{fill}}, d_in[DATA_W-1:SH]} :
                                 {d_in[DATA_W-1-SH:0], {SH{1'b0}}};
    end

    assign y = g_stage[AMT_W-1].d_out;

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage valid/ready shift pipe: decode + operand staging in S1, barrel
// shift between S1 and S2, registered result/tag/illegal flag in S2.
module shift_exec_pipe
    import shift_exec_pipe_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_rs,
    input  logic [31:0]       in_rt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    s1_data_t          dec_next;
    s1_data_t          s1_data_reg;
    logic              s1_valid_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic              s2_valid_reg;
    logic [31:0]       s2_result_reg;
    logic [TAG_W-1:0]  s2_tag_reg;
    logic              s2_illegal_reg;
    logic [31:0]       mux_result;
    logic              s2_adv;
    logic              accept;
    logic              retire;

    // Only rs[4:0] selects a variable amount; the upper bits never matter.
    logic rs_upper_unused;
    assign rs_upper_unused = ^in_rs[31:AMT_W];

    always_comb begin
        dec_next.rt      = in_rt;
        dec_next.amt     = '0;
        dec_next.right   = 1'b0;
        dec_next.arith   = 1'b0;
        dec_next.illegal = 1'b1;
        case (in_funct)
            F_SLL:  begin dec_next.amt = in_shamt;                                                   dec_next.illegal = 1'b0; end
            F_SRL:  begin dec_next.amt = in_shamt;   dec_next.right = 1'b1;                          dec_next.illegal = 1'b0; end
            F_SRA:  begin dec_next.amt = in_shamt;   dec_next.right = 1'b1; dec_next.arith = 1'b1;   dec_next.illegal = 1'b0; end
            F_SLLV: begin dec_next.amt = in_rs[4:0];                                                 dec_next.illegal = 1'b0; end
            F_SRLV: begin dec_next.amt = in_rs[4:0]; dec_next.right = 1'b1;                          dec_next.illegal = 1'b0; end
            F_SRAV: begin dec_next.amt = in_rs[4:0]; dec_next.right = 1'b1; dec_next.arith = 1'b1;   dec_next.illegal = 1'b0; end
            default: ;
        endcase
    end

    assign s2_adv   = s1_valid_reg & (!s2_valid_reg | out_ready);
    assign in_ready = !flush & (!s1_valid_reg | s2_adv);
    assign accept   = in_valid & in_ready;
    assign retire   = s2_valid_reg & out_ready;

    shift_mux u_shift_mux (
        .d     (s1_data_reg.rt),
        .sa    (s1_data_reg.amt),
        .right (s1_data_reg.right),
        .arith (s1_data_reg.arith),
        .y     (mux_result)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_reg   <= 1'b0;
            s1_data_reg    <= '0;
            s1_tag_reg     <= '0;
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= '0;
            s2_tag_reg     <= '0;
            s2_illegal_reg <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_reg <= 1'b0;
                s2_valid_reg <= 1'b0;
            end else begin
                if (accept)      s1_valid_reg <= 1'b1;
                else if (s2_adv) s1_valid_reg <= 1'b0;
                if (s2_adv)      s2_valid_reg <= 1'b1;
                else if (retire) s2_valid_reg <= 1'b0;
            end
            // Data follows its load enable only; flush just kills the valids.
            if (accept) begin
                s1_data_reg <= dec_next;
                s1_tag_reg  <= in_tag;
            end
            if (s2_adv) begin
                s2_result_reg  <= mux_result;
                s2_tag_reg     <= s1_tag_reg;
                s2_illegal_reg <= s1_data_reg.illegal;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_result  = s2_result_reg;
    assign out_tag     = s2_tag_reg;
    assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed self-checking bench for shift_exec_pipe: latency, shift types,
// throughput, backpressure, illegal funct, flush and async reset.
module tb_shift_exec_pipe;

    logic        clk = 1'b0;
    logic        clrn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_exec_pipe #(.TAG_W(5)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one op from just after a negedge; returns just after the
    // negedge following the accepting edge, with in_valid dropped.
    task automatic offer(input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] tag);
        in_valid = 1'b1; in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_tag = tag;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                $display("accept funct=%b tag=%0d rt=%h", f, tag, rt);
                return;
            end
            @(negedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL offer_timeout tag=%0d in_ready=%b required 1", tag, in_ready);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct = 6'h3f; in_shamt = 5'd0; in_rs = '0; in_rt = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0)    begin errors++; $display("FAIL reset_result got %h want 0", out_result); end
        checks++; if (out_tag !== 5'd0)        begin errors++; $display("FAIL reset_tag got %0d want 0", out_tag); end
        checks++; if (out_illegal !== 1'b0)    begin errors++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
        @(negedge clk);
        clrn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)       begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset released");
    endtask

    task automatic test_sll();
        drain();
        offer(6'b000000, 5'd31, 32'h0, 32'h0000_0001, 5'd3);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sll_latency_early got %b want 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1)            begin errors++; $display("FAIL sll_valid got %b want 1", out_valid); end
        checks++; if (out_result !== 32'h8000_0000)  begin errors++; $display("FAIL sll_result got %h want 80000000", out_result); end
        checks++; if (out_tag !== 5'd3)              begin errors++; $display("FAIL sll_tag got %0d want 3", out_tag); end
        checks++; if (out_illegal !== 1'b0)          begin errors++; $display("FAIL sll_illegal got %b want 0", out_illegal); end
        $display("retire tag=%0d result=%h", out_tag, out_result);
    endtask

    task automatic test_variable();
        drain();
        offer(6'b000111, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd5);
        @(negedge clk); #1;
        checks++; if (out_result !== 32'hF800_000F) begin errors++; $display("FAIL srav_result got %h want f800000f", out_result); end
        checks++; if (out_tag !== 5'd5)             begin errors++; $display("FAIL srav_tag got %0d want 5", out_tag); end
        $display("retire tag=%0d result=%h", out_tag, out_result);
        drain();
        offer(6'b000110, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd6);
        @(negedge clk); #1;
        checks++; if (out_result !== 32'h0800_000F) begin errors++; $display("FAIL srlv_result got %h want 0800000f", out_result); end
        $display("retire tag=%0d result=%h", out_tag, out_result);
        drain();
        offer(6'b000011, 5'd31, 32'h0, 32'h8000_0000, 5'd7);
        @(negedge clk); #1;
        checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_result got %h want ffffffff", out_result); end
        $display("retire tag=%0d result=%h", out_tag, out_result);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
        drain();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_funct = 6'b000000; in_shamt = 5'(c);
                in_rs = '0; in_rt = 32'h1; in_tag = 5'(10 + c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d got %b want 1", c, in_ready); end
            end
            if (c >= 2 && c < 6) begin
                checks++; if (out_valid !== 1'b1)            begin errors++; $display("FAIL b2b_valid c=%0d got %b want 1", c, out_valid); end
                checks++; if (out_tag !== 5'(10 + c - 2))    begin errors++; $display("FAIL b2b_tag c=%0d got %0d want %0d", c, out_tag, 10 + c - 2); end
                checks++; if (out_result !== exp_res[c - 2]) begin errors++; $display("FAIL b2b_result c=%0d got %h want %h", c, out_result, exp_res[c - 2]); end
                $display("retire tag=%0d result=%h", out_tag, out_result);
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d got %b want 0", c, out_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic        exp_rdy [6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_vld [9]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  exp_tag [9]   = '{5'd0, 5'd0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd21, 5'd22, 5'd0};
        logic [31:0] exp_res [9]   = '{32'h0, 32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                                       32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0};
        int idx = 0;
        drain();
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 5);
            if (idx < 3) begin
                in_valid = 1'b1; in_funct = 6'b000010; in_shamt = 5'(idx + 1);
                in_rs = '0; in_rt = 32'h8000_0000; in_tag = 5'(20 + idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 6) begin
                checks++; if (in_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, exp_rdy[c]); end
            end
            if (c == 5) begin
                checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted_before_release got %0d want 2", idx); end
            end
            checks++; if (out_valid !== exp_vld[c]) begin errors++; $display("FAIL bp_valid c=%0d got %b want %b", c, out_valid, exp_vld[c]); end
            if (exp_vld[c]) begin
                checks++; if (out_tag !== exp_tag[c])    begin errors++; $display("FAIL bp_tag c=%0d got %0d want %0d", c, out_tag, exp_tag[c]); end
                checks++; if (out_result !== exp_res[c]) begin errors++; $display("FAIL bp_result c=%0d got %h want %h", c, out_result, exp_res[c]); end
            end
            if (in_valid && in_ready) begin
                $display("accept tag=%0d", in_tag);
                idx++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        drain();
        offer(6'b100000, 5'd7, 32'h0000_0003, 32'h1234_5678, 5'd9);
        @(negedge clk); #1;
        checks++; if (out_illegal !== 1'b1)         begin errors++; $display("FAIL illegal_flag got %b want 1", out_illegal); end
        checks++; if (out_result !== 32'h1234_5678) begin errors++; $display("FAIL illegal_result got %h want 12345678", out_result); end
        checks++; if (out_tag !== 5'd9)             begin errors++; $display("FAIL illegal_tag got %0d want 9", out_tag); end
        $display("retire tag=%0d result=%h illegal=%b", out_tag, out_result, out_illegal);
    endtask

    task automatic test_flush_and_reset();
        drain();
        out_ready = 1'b0;
        offer(6'b000000, 5'd1, 32'h0, 32'h1, 5'd1);
        offer(6'b000000, 5'd2, 32'h0, 32'h1, 5'd2);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_pre_in_ready got %b want 0", in_ready); end
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_funct = 6'b000000; in_shamt = 5'd3; in_rt = 32'h1; in_tag = 5'd3;
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_post_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_retire c=%0d got %b want 0", c, out_valid); end
        end
        $display("flush done");

        out_ready = 1'b0;
        offer(6'b000000, 5'd2, 32'h0, 32'h3, 5'd4);
        offer(6'b000000, 5'd2, 32'h0, 32'h5, 5'd5);
        #1;
        checks++; if (out_result !== 32'hC) begin errors++; $display("FAIL rst_pre_result got %h want c", out_result); end
        #2;
        clrn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", out_result); end
        checks++; if (out_tag !== 5'd0)     begin errors++; $display("FAIL rst_mid_tag got %0d want 0", out_tag); end
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_post_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_post_valid got %b want 0", out_valid); end
        $display("mid-stream reset done");

        out_ready = 1'b1;
        offer(6'b000000, 5'd0, 32'h0, 32'hA5A5_5A5A, 5'd7);
        @(negedge clk); #1;
        checks++; if (out_result !== 32'hA5A5_5A5A) begin errors++; $display("FAIL amt0_result got %h want a5a55a5a", out_result); end
        checks++; if (out_tag !== 5'd7)             begin errors++; $display("FAIL amt0_tag got %0d want 7", out_tag); end
        $display("retire tag=%0d result=%h", out_tag, out_result);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_variable();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
